// File: rtl/ctrl_pipe_pkg.sv
// Control-word layout and default per-stage keep masks shared by the pipeline control chain.
package ctrl_pipe_pkg;

    localparam int CTRL_W = 13;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 3;
    localparam int AM      = 4;
    localparam int S_EN    = 5;
    localparam int LOAD    = 6;
    localparam int RF_EN   = 7;
    localparam int SIZE    = 8;
    localparam int RW_EN   = 9;
    localparam int MEM_EN  = 10;
    localparam int BL      = 11;
    localparam int B       = 12;

    localparam logic [CTRL_W-1:0] ID_EX_MASK  = 13'h1FFF;
    localparam logic [CTRL_W-1:0] EX_MEM_MASK = 13'h07C0;
    localparam logic [CTRL_W-1:0] MEM_WB_MASK = 13'h0080;

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: masks the incoming word, zeroes it when killed, async reset.
// Latency 1 cycle; never stalls, a kill simply loads a bubble.
module ctrl_stage_reg #(
    parameter int          W    = 13,
    parameter logic [W-1:0] MASK = '1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] ctrl_i,
    input  logic         kill_i,
    output logic [W-1:0] ctrl_o,
    output logic         valid_o
);

    logic [W-1:0] ctrl_q, ctrl_d;
    logic         valid_q, valid_d;

    always_comb begin
        ctrl_d  = kill_i ? '0 : (ctrl_i & MASK);
        valid_d = ~kill_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    assign ctrl_o  = ctrl_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Carries decoded control words ID/EX -> EX/MEM -> MEM/WB with bubbles, flush, load enables and event counters.
// Slice k holds a word k+1 cycles after capture; stall/flush act only at the stage-0 boundary.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int                           CTRL_W    = ctrl_pipe_pkg::CTRL_W,
    parameter int                           STAGES    = 3,
    parameter logic [STAGES*CTRL_W-1:0]     KEEP_MASK = {MEM_WB_MASK, EX_MEM_MASK, ID_EX_MASK},
    parameter int                           CNT_W     = 8
) (
    input  logic                     clk,
    input  logic                     R,
    input  logic [CTRL_W-1:0]        id_ctrl,
    input  logic                     id_valid,
    input  logic                     hazard_stall,
    input  logic                     branch_flush,
    input  logic                     cnt_clr,
    output logic [STAGES*CTRL_W-1:0] stage_ctrl,
    output logic [STAGES-1:0]        stage_valid,
    output logic                     pc_le,
    output logic                     if_id_le,
    output logic                     if_id_clr,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CTRL_W-1:0] ctrl_in [STAGES];
    logic              kill_v  [STAGES];

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign ctrl_in[k] = id_ctrl;
                assign kill_v[k]  = hazard_stall | branch_flush | ~id_valid;
            end else begin : g_tail
                // An invalid upstream stage is propagated as a bubble, keeping ctrl zero when valid is zero.
                assign ctrl_in[k] = stage_ctrl[(k-1)*CTRL_W +: CTRL_W];
                assign kill_v[k]  = ~stage_valid[k-1];
            end

            ctrl_stage_reg #(
                .W    (CTRL_W),
                .MASK (KEEP_MASK[k*CTRL_W +: CTRL_W])
            ) u_stage (
                .clk     (clk),
                .rst     (R),
                .ctrl_i  (ctrl_in[k]),
                .kill_i  (kill_v[k]),
                .ctrl_o  (stage_ctrl[k*CTRL_W +: CTRL_W]),
                .valid_o (stage_valid[k])
            );
        end
    endgenerate

    // A flush redirects fetch, so it overrides a simultaneous load-use hold.
    assign pc_le     = ~R & (~hazard_stall | branch_flush);
    assign if_id_le  = ~R & (~hazard_stall | branch_flush);
    assign if_id_clr = ~R & branch_flush;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             stall_inc, flush_inc;

    assign stall_inc = hazard_stall & ~branch_flush;
    assign flush_inc = branch_flush;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
